plru_victim_sel: RTL and testbench

- Replacement-side companion to the 4-way L1 cache's tree pseudo-LRU update logic.
- Holds a 3-bit PLRU state per set and applies hit updates.
- On a miss, answers victim requests with the way to evict, one cycle after the request.
- Sits in the cache datapath between the tag-compare/hit logic and the cache control FSM's allocate path.

---
 rtl/lc3b_types.sv | 9 +
 rtl/plru_victim_sel_if.sv | 33 +++
 rtl/plru_victim_dec.sv | 18 +
 rtl/plru_victim_sel.sv | 111 +++++++++++
 tb/tb_plru_victim_sel.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b datapath types; way-index and PLRU state types
package lc3b_types;

    typedef logic [1:0] lc3b_2bit;
    typedef logic [2:0] lc3b_3bit;

    localparam lc3b_3bit PLRU_RESET = 3'b000;

endpackage

// File: rtl/plru_victim_sel_if.sv
// rtl/plru_victim_sel_if.sv - hit/alloc/victim-request bus between cache control and PLRU block
interface plru_victim_sel_if
    import lc3b_types::*;
#(
    parameter int INDEX_W = 3
);

    logic               hit_valid;
    logic [INDEX_W-1:0] hit_index;
    lc3b_2bit           hit_way;
    logic               vreq;
    logic [INDEX_W-1:0] vreq_index;
    logic [3:0]         way_valid;
    logic               vack;
    lc3b_2bit           victim_way;
    logic               alloc;
    logic [INDEX_W-1:0] alloc_index;

    modport master (
        output hit_valid, hit_index, hit_way,
        output vreq, vreq_index, way_valid,
        output alloc, alloc_index,
        input  vack, victim_way
    );

    modport slave (
        input  hit_valid, hit_index, hit_way,
        input  vreq, vreq_index, way_valid,
        input  alloc, alloc_index,
        output vack, victim_way
    );

endinterface

// File: rtl/plru_victim_dec.sv
// rtl/plru_victim_dec.sv - combinational tree-PLRU victim decode, 3-bit state to way
module plru_victim_dec
    import lc3b_types::*;
(
    input  lc3b_3bit state,
    output lc3b_2bit way
);

    // Walk away from the most recently used half, then away from its MRU way.
    always_comb begin
        if (state[2]) begin
            way = state[0] ? 2'd3 : 2'd2;
        end else begin
            way = state[1] ? 2'd1 : 2'd0;
        end
    end

endmodule

// File: rtl/plru_victim_sel.sv
// rtl/plru_victim_sel.sv - per-set tree PLRU state and victim responder; PLRU_INVALID_FIRST_EN prefers invalid ways
module plru_victim_sel
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8,
    parameter int INDEX_W  = 3
)(
    input  logic              clk,
    input  logic              reset,
    plru_victim_sel_if.slave  bus
);

    lc3b_3bit lru_q [NUM_SETS];
    lc3b_3bit lru_d [NUM_SETS];
    logic     vack_q;
    logic     vack_d;
    lc3b_2bit victim_way_q;
    lc3b_2bit victim_way_d;

    logic     hit_en;
    logic     alloc_en;
    lc3b_3bit hit_state;
    lc3b_3bit alloc_base;
    lc3b_3bit req_state;
    lc3b_2bit plru_way;
    lc3b_2bit pick_way;

    function automatic logic in_range(input logic [INDEX_W-1:0] idx);
        return 32'(idx) < 32'(NUM_SETS);
    endfunction

    function automatic lc3b_3bit plru_touch(input lc3b_3bit s, input lc3b_2bit w);
        case (w)
            2'd0:    return {2'b11, s[0]};
            2'd1:    return {2'b10, s[0]};
            2'd2:    return {1'b0, s[1], 1'b1};
            default: return {1'b0, s[1], 1'b0};
        endcase
    endfunction

    // The alloc fills the way presented on the last vack, and lands after any same-set hit.
    always_comb begin
        hit_en     = bus.hit_valid && in_range(bus.hit_index);
        alloc_en   = bus.alloc && in_range(bus.alloc_index);
        hit_state  = plru_touch(lru_q[bus.hit_index], bus.hit_way);
        alloc_base = (hit_en && (bus.hit_index == bus.alloc_index)) ? hit_state
                                                                    : lru_q[bus.alloc_index];
        for (int i = 0; i < NUM_SETS; i++) begin
            lru_d[i] = lru_q[i];
        end
        if (hit_en) begin
            lru_d[bus.hit_index] = hit_state;
        end
        if (alloc_en) begin
            lru_d[bus.alloc_index] = plru_touch(alloc_base, victim_way_q);
        end
    end

    // Requests see this cycle's hit/alloc updates by decoding the next-state value.
    always_comb begin
        req_state = in_range(bus.vreq_index) ? lru_d[bus.vreq_index] : PLRU_RESET;
    end

    plru_victim_dec u_dec (
        .state (req_state),
        .way   (plru_way)
    );

`ifdef PLRU_INVALID_FIRST_EN
    always_comb begin
        pick_way = plru_way;
        if (bus.way_valid != 4'b1111) begin
            pick_way = 2'd3;
            for (int w = 3; w >= 0; w--) begin
                if (!bus.way_valid[w]) begin
                    pick_way = 2'(w);
                end
            end
        end
    end
`else
    logic unused_way_valid;
    assign unused_way_valid = ^bus.way_valid;
    assign pick_way         = plru_way;
`endif

    always_comb begin
        vack_d       = bus.vreq;
        victim_way_d = bus.vreq ? pick_way : victim_way_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= PLRU_RESET;
            end
            vack_q       <= 1'b0;
            victim_way_q <= 2'd0;
        end else begin
            for (int i = 0; i < NUM_SETS; i++) begin
                lru_q[i] <= lru_d[i];
            end
            vack_q       <= vack_d;
            victim_way_q <= victim_way_d;
        end
    end

    assign bus.vack       = vack_q;
    assign bus.victim_way = victim_way_q;

endmodule

// File: tb/tb_plru_victim_sel.sv
// tb/tb_plru_victim_sel.sv - vector table, reset corner and randomized model check for plru_victim_sel
module tb_plru_victim_sel;

    localparam int NUM_SETS = 8;
    localparam int INDEX_W  = 3;
`ifdef PLRU_INVALID_FIRST_EN
    localparam bit INV_FIRST = 1'b1;
`else
    localparam bit INV_FIRST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    plru_victim_sel_if #(.INDEX_W(INDEX_W)) bus ();

    plru_victim_sel #(.NUM_SETS(NUM_SETS), .INDEX_W(INDEX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       hv;
        logic [2:0] hi;
        logic [1:0] hw;
        logic       vr;
        logic [2:0] vi;
        logic [3:0] wv;
        logic       al;
        logic [2:0] ai;
        logic       ev;
        logic [1:0] ew;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: per set, which half was touched last and the last-touched way inside each half.
    int m_half [NUM_SETS];
    int m_lo   [NUM_SETS];
    int m_hi   [NUM_SETS];
    int m_victim;
    int m_vack;

    function automatic void model_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_half[s] = 1;
            m_lo[s]   = 1;
            m_hi[s]   = 3;
        end
        m_victim = 0;
        m_vack   = 0;
    endfunction

    function automatic void model_touch(input int s, input int w);
        if (w < 2) begin
            m_half[s] = 0;
            m_lo[s]   = w;
        end else begin
            m_half[s] = 1;
            m_hi[s]   = w;
        end
    endfunction

    function automatic int model_pick(input int s, input logic [3:0] wv);
        if (INV_FIRST && wv != 4'b1111) begin
            for (int w = 0; w < 4; w++) begin
                if (!wv[w]) return w;
            end
        end
        if (m_half[s] == 0) return (m_hi[s] == 2) ? 3 : 2;
        return (m_lo[s] == 0) ? 1 : 0;
    endfunction

    function automatic vec_t mk(input logic hv, input int hi, input int hw,
                                input logic vr, input int vi, input logic [3:0] wv,
                                input logic al, input int ai,
                                input logic ev, input int ew);
        vec_t v;
        v.hv = hv; v.hi = 3'(hi); v.hw = 2'(hw);
        v.vr = vr; v.vi = 3'(vi); v.wv = wv;
        v.al = al; v.ai = 3'(ai);
        v.ev = ev; v.ew = 2'(ew);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.hit_valid   = v.hv;
        bus.hit_index   = v.hi;
        bus.hit_way     = v.hw;
        bus.vreq        = v.vr;
        bus.vreq_index  = v.vi;
        bus.way_valid   = v.wv;
        bus.alloc       = v.al;
        bus.alloc_index = v.ai;
        if (v.hv) model_touch(int'(v.hi), int'(v.hw));
        if (v.al) model_touch(int'(v.ai), m_victim);
        m_vack = int'(v.vr);
        if (v.vr) m_victim = model_pick(int'(v.vi), v.wv);
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 4'hf, 0, 0, 0, 0);

        tbl.push_back(mk(0, 0, 0, 1, 2, 4'hf, 0, 0, 1, 0));
        for (int s = 0; s < NUM_SETS; s++) begin
            tbl.push_back(mk(0, 0, 0, 1, s, 4'hf, 0, 0, 1, 0));
        end
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'hf, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 4'hf, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 0, 4'hf, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4'hf, 0, 0, 1, 0));
        tbl.push_back(mk(1, 5, 3, 1, 5, 4'hf, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6, 1, 1, 6, 4'hf, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 6, 4'hf, 1, 6, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'hf, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hf, 0, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1, 0, 0, 4'hf, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hf, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'hf, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 4'hf, 0, 0, 1, 3));
        tbl.push_back(mk(1, 4, 0, 0, 0, 4'hf, 0, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 4, 4'hb, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 4, 4'hd, 0, 0, 1, INV_FIRST ? 1 : 2));
        tbl.push_back(mk(0, 0, 0, 1, 4, 4'h0, 0, 0, 1, INV_FIRST ? 0 : 2));
        tbl.push_back(mk(0, 0, 0, 1, 4, 4'hf, 0, 0, 1, 2));
        tbl.push_back(mk(1, 3, 0, 0, 0, 4'hf, 1, 7, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 7, 4'hf, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 4'hf, 0, 0, 1, 2));

        reset = 1'b1;
        drive(idle);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset vack", int'(bus.vack), 0);
        check("reset victim_way", int'(bus.victim_way), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i]);
            check($sformatf("vec%0d vack", i), int'(bus.vack), int'(tbl[i].ev));
            check($sformatf("vec%0d victim_way", i), int'(bus.victim_way), int'(tbl[i].ew));
        end

        // A request whose cycle is cut short by reset must never produce a vack.
        drive(mk(0, 0, 0, 1, 3, 4'hf, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("midreq reset vack", int'(bus.vack), 0);
        check("midreq reset victim_way", int'(bus.victim_way), 0);
        drive(idle);
        model_reset();
        @(posedge clk);
        #1;
        check("held reset vack", int'(bus.vack), 0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(0, 0, 0, 1, 3, 4'hf, 0, 0, 1, 0));
        check("post reset vack", int'(bus.vack), 1);
        check("post reset victim_way", int'(bus.victim_way), 0);
        apply(idle);
        check("post reset idle vack", int'(bus.vack), 0);

        for (int n = 0; n < 3000; n++) begin
            vec_t r;
            r = mk($urandom_range(0, 1) == 1, $urandom_range(0, NUM_SETS - 1), $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, $urandom_range(0, NUM_SETS - 1),
                   ($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom_range(0, 15)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, NUM_SETS - 1), 0, 0);
            apply(r);
            check($sformatf("rand%0d vack", n), int'(bus.vack), m_vack);
            check($sformatf("rand%0d victim_way", n), int'(bus.victim_way), m_victim);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
